// File: rtl/softmax_sched_pkg.sv
// softmax_sched_pkg: shared constants and row/result types for the softmax row scheduler.
// No ports; imported by sched_sync_fifo users and the softmax_row_scheduler top.
package softmax_sched_pkg;
    localparam int N         = 32;
    localparam int BIT_WIDTH = 16;
    localparam int NUM_REQ   = 4;
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int ROW_W     = N * BIT_WIDTH;
    typedef logic [N-1:0][BIT_WIDTH-1:0] row_t;
    typedef struct packed {
        logic [ID_W-1:0] id;
        row_t            row;
    } res_entry_t;
endpackage

// File: rtl/sched_sync_fifo.sv
// sched_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count.
// Ports: clk/rst (async active-high), push/push_data write side, pop/pop_data read side
// (pop_data is the head, forced to 0 while empty), count = current occupancy.
module sched_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Memory is not reset, so the head is masked until something has been written.
    assign pop_data = (count == '0) ? '0 : mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));
endmodule

// File: rtl/softmax_row_scheduler.sv
// softmax_row_scheduler: round-robin sharing of one fixed-latency softmax engine among NUM_REQ requesters.
// Ports: i_clk/i_rst (async active-high); i_req_valid/i_req_data/o_req_ready requester side;
// o_sm_valid/o_sm_data issue to engine, i_sm_valid/i_sm_data engine return;
// o_res_valid/i_res_ready/o_res_data/o_res_id result stream; o_inflight rows in engine;
// o_err_unexpected sticky flag for an engine return with no outstanding tag.
module softmax_row_scheduler
    import softmax_sched_pkg::*;
#(
    parameter int RES_DEPTH = 32,
    parameter int ISSUE_GAP = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ*ROW_W-1:0]     i_req_data,
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic                         o_sm_valid,
    output logic [ROW_W-1:0]             o_sm_data,
    input  logic                         i_sm_valid,
    input  logic [ROW_W-1:0]             i_sm_data,
    output logic                         o_res_valid,
    input  logic                         i_res_ready,
    output logic [ROW_W-1:0]             o_res_data,
    output logic [ID_W-1:0]              o_res_id,
    output logic [$clog2(RES_DEPTH):0]   o_inflight,
    output logic                         o_err_unexpected
);
    localparam int CW = $clog2(RES_DEPTH) + 1;
    localparam int GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam logic [CW:0] CREDITS = RES_DEPTH;

    logic [ID_W-1:0] ptr, win, idx, issue_id, tag_head;
    logic            found, allow, accept, ret;
    logic [GW-1:0]   gap;
    logic [CW:0]     used;
    logic [CW-1:0]   tag_count, res_count;
    res_entry_t      res_head;

    // o_inflight counts from the accept edge, so a row accepted last cycle is already
    // charged even though it only reaches the tag FIFO this cycle.
    assign used  = {1'b0, o_inflight} + {1'b0, res_count};
    assign allow = (used < CREDITS) && (gap == '0) && !o_err_unexpected;
    assign ret   = i_sm_valid && (tag_count != '0);

    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && i_req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        // Reset gates the combinational ready so every output reads 0 while i_rst is high.
        accept = allow && found && !i_rst;
        o_req_ready = '0;
        o_req_ready[win] = accept;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr              <= ID_W'(NUM_REQ - 1);
            gap              <= '0;
            o_sm_valid       <= 1'b0;
            o_sm_data        <= '0;
            issue_id         <= '0;
            o_inflight       <= '0;
            o_err_unexpected <= 1'b0;
        end else begin
            o_sm_valid       <= accept;
            o_inflight       <= o_inflight + CW'(accept) - CW'(ret);
            o_err_unexpected <= o_err_unexpected | (i_sm_valid && tag_count == '0);
            if (accept) begin
                ptr       <= win;
                issue_id  <= win;
                o_sm_data <= i_req_data[win*ROW_W +: ROW_W];
                gap       <= GW'(ISSUE_GAP);
            end else if (gap != '0) begin
                gap <= gap - 1'b1;
            end
        end
    end

    sched_sync_fifo #(.W(ID_W), .DEPTH(RES_DEPTH)) u_tag_fifo (
        .clk(i_clk), .rst(i_rst),
        .push(o_sm_valid), .push_data(issue_id),
        .pop(ret), .pop_data(tag_head), .count(tag_count)
    );

    sched_sync_fifo #(.W($bits(res_entry_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk(i_clk), .rst(i_rst),
        .push(ret), .push_data({tag_head, i_sm_data}),
        .pop(o_res_valid && i_res_ready), .pop_data(res_head), .count(res_count)
    );

    assign o_res_valid = (res_count != '0);
    assign o_res_id    = res_head.id;
    assign o_res_data  = res_head.row;
endmodule

// File: tb/tb_softmax_row_scheduler.sv
// tb_softmax_row_scheduler: directed self-checking bench for softmax_row_scheduler with a 12-cycle engine model.
// No ports; drives one gap-0 instance with an engine model and one gap-3 instance for issue spacing.
module tb_softmax_row_scheduler;
    import softmax_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*ROW_W-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]       ready;
    logic                     sm_valid, eng_valid, res_valid, err;
    logic                     res_ready = 1'b0;
    logic                     inj = 1'b0;
    logic [ROW_W-1:0]         sm_data, eng_data, res_data;
    logic [ID_W-1:0]          res_id;
    logic [5:0]               inflight;

    logic [NUM_REQ-1:0]       g_valid = '0;
    logic [NUM_REQ*ROW_W-1:0] g_data  = '0;
    logic [NUM_REQ-1:0]       g_ready;
    logic                     g_sm_valid, g_res_valid, g_err;
    logic [ROW_W-1:0]         g_sm_data, g_res_data;
    logic [ID_W-1:0]          g_res_id;
    logic [5:0]               g_inflight;

    softmax_row_scheduler #(.RES_DEPTH(32), .ISSUE_GAP(0)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(ready),
        .o_sm_valid(sm_valid), .o_sm_data(sm_data),
        .i_sm_valid(eng_valid), .i_sm_data(eng_data),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data), .o_res_id(res_id),
        .o_inflight(inflight), .o_err_unexpected(err)
    );

    softmax_row_scheduler #(.RES_DEPTH(32), .ISSUE_GAP(3)) dut_g (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(g_valid), .i_req_data(g_data), .o_req_ready(g_ready),
        .o_sm_valid(g_sm_valid), .o_sm_data(g_sm_data),
        .i_sm_valid(1'b0), .i_sm_data('0),
        .o_res_valid(g_res_valid), .i_res_ready(1'b1),
        .o_res_data(g_res_data), .o_res_id(g_res_id),
        .o_inflight(g_inflight), .o_err_unexpected(g_err)
    );

    logic [11:0]      pv;
    logic [ROW_W-1:0] pd [12];
    always @(posedge clk or posedge rst) pv <= rst ? '0 : {pv[10:0], sm_valid};
    always @(posedge clk) begin
        pd[0] <= sm_data;
        for (int i = 1; i < 12; i++) pd[i] <= pd[i-1];
    end
    assign eng_valid = pv[11] | inj;
    assign eng_data  = pd[11];

    function automatic logic [ROW_W-1:0] fill(logic [15:0] v);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*BIT_WIDTH +: BIT_WIDTH] = v + 16'(i);
        return r;
    endfunction

    task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int n, got, last, pulses;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_sm_valid", sm_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err", err, 0);
        do_reset();
        chk("post_rst_ready", ready, 0);

        // Single row from requester 2
        req_valid = 4'b0100;
        req_data[2*ROW_W +: ROW_W] = '0;
        #1;
        chk("t1_ready", ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("t1_ready_drop", ready, 0);
        chk("t1_sm_valid", sm_valid, 1);
        chk("t1_sm_data", sm_data, 0);
        chk("t1_inflight", inflight, 1);
        tick();
        chk("t1_sm_pulse", sm_valid, 0);
        for (int c = 0; c < 40 && !res_valid; c++) tick();
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_id", res_id, 2);
        chk("t1_res_data", res_data, 0);
        chk("t1_inflight_back", inflight, 0);
        res_ready = 1'b1;
        tick();
        chk("t1_popped", res_valid, 0);

        // Round robin with all requesters valid
        do_reset();
        for (int r = 0; r < NUM_REQ; r++) req_data[r*ROW_W +: ROW_W] = fill(16'h1000 * 16'(r + 1));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_grant", ready, 4'b0001 << (k % 4));
            tick();
        end
        req_valid = '0;
        got = 0;
        for (int c = 0; c < 80 && got < 8; c++) begin
            if (res_valid) begin
                chk("t2_res_id", res_id, got % 4);
                chk("t2_res_data", res_data, fill(16'h1000 * 16'((got % 4) + 1)));
                got++;
            end
            tick();
        end
        chk("t2_res_count", got, 8);

        // Backpressure: credits run out at RES_DEPTH
        res_ready = 1'b0;
        do_reset();
        req_valid = 4'hF;
        #1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (ready != '0) n++;
            tick();
        end
        chk("t3_issue_count", n, 32);
        chk("t3_ready_blocked", ready, 0);
        chk("t3_inflight", inflight, 0);
        chk("t3_head_id", res_id, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        #1;
        chk("t3_one_credit", ready, 4'b0001);
        tick();
        chk("t3_reblocked", ready, 0);
        chk("t3_reissue", sm_valid, 1);
        req_valid = '0;

        // Issue gap of 3 on the second instance
        g_data[1*ROW_W +: ROW_W] = fill(16'h00AB);
        g_valid = 4'b0010;
        last = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (g_sm_valid) begin
                if (pulses == 0) chk("t4_data", g_sm_data, fill(16'h00AB));
                else chk("t4_spacing", i - last, 4);
                last = i;
                pulses++;
            end
        end
        g_valid = '0;
        chk("t4_pulses", pulses, 5);
        chk("t4_err", g_err, 0);

        // Async reset with rows in flight and results buffered
        res_ready = 1'b0;
        do_reset();
        req_valid = 4'hF;
        tick(); tick(); tick();
        req_valid = '0;
        for (int c = 0; c < 20; c++) tick();
        chk("t6_buffered", res_valid, 1);
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) tick();
        chk("t6_inflight", inflight, 5);
        chk("t6_sm_valid_pre", sm_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_ready", ready, 0);
        chk("t6_sm_valid", sm_valid, 0);
        chk("t6_sm_data", sm_data, 0);
        chk("t6_res_valid", res_valid, 0);
        chk("t6_res_id", res_id, 0);
        chk("t6_res_data", res_data, 0);
        chk("t6_inflight_zero", inflight, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_priority", ready, 4'b0001);
        req_valid = '0;
        for (int c = 0; c < 20; c++) tick();
        chk("t6_no_stale", res_valid, 0);
        chk("t6_no_err", err, 0);

        // Unexpected engine return
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("t5_err", err, 1);
        chk("t5_no_push", res_valid, 0);
        chk("t5_inflight", inflight, 0);
        req_valid = 4'hF;
        #1;
        chk("t5_blocked", ready, 0);
        tick(); tick(); tick();
        chk("t5_err_sticky", err, 1);
        chk("t5_no_issue", sm_valid, 0);
        req_valid = '0;
        do_reset();
        chk("t5_err_cleared", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
